// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - PRESENT-80 constants, state encoding and key/permutation helpers
package present_pkg;

   localparam int ROUNDS = 31;

   localparam logic [3:0] SBOX [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   localparam logic [3:0] SBOX_INV [16] = '{
      4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
      4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
   };

   typedef enum logic [2:0] {
      IDLE,
      KEXP,
      WHITEN,
      DEC,
      DONE
   } state_t;

   // Output bit i takes input bit 16*(i mod 4) + i/4; pure wiring.
   function automatic logic [63:0] inv_player(input logic [63:0] din);
      logic [63:0] dout;
      dout = '0;
      for (int i = 0; i < 64; i++) begin
         dout[i] = din[16 * (i % 4) + (i / 4)];
      end
      return dout;
   endfunction

   // Forward schedule: rotate left by 61, S-box on the top nibble, counter into K[19:15].
   function automatic logic [79:0] key_update_fwd(input logic [79:0] k, input logic [4:0] rc);
      logic [79:0] r;
      r = {k[18:0], k[79:19]};
      r[79:76] = SBOX[r[79:76]];
      r[19:15] = r[19:15] ^ rc;
      return r;
   endfunction

   // Exact inverse of key_update_fwd for the same counter value.
   function automatic logic [79:0] key_update_inv(input logic [79:0] k, input logic [4:0] rc);
      logic [79:0] r;
      r = k;
      r[19:15] = r[19:15] ^ rc;
      r[79:76] = SBOX_INV[r[79:76]];
      return {r[60:0], r[79:61]};
   endfunction

endpackage

// File: rtl/present_inv_sbox_layer.sv
// rtl/present_inv_sbox_layer.sv - 16 parallel PRESENT inverse S-box lookups
module present_inv_sbox_layer
   import present_pkg::*;
(
   input  logic [63:0] data_i,
   output logic [63:0] data_o
);

   // Each nibble is substituted independently.
   always_comb begin
      data_o = '0;
      for (int n = 0; n < 16; n++) begin
         data_o[4 * n +: 4] = SBOX_INV[data_i[4 * n +: 4]];
      end
   end

endmodule

// File: rtl/present80_decrypt_core.sv
// rtl/present80_decrypt_core.sv - iterative PRESENT-80 decryption, one round per clock
module present80_decrypt_core
   import present_pkg::*;
#(
   parameter int ROUNDS = present_pkg::ROUNDS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [79:0] key,
   input  logic [63:0] ciphertext,
   output logic        busy,
   output logic        done,
   output logic [63:0] plaintext
);

   localparam logic [4:0] RC_LAST = 5'(ROUNDS);

   state_t      state_q;
   state_t      state_d;
   logic [79:0] key_q;
   logic [63:0] data_q;
   logic [4:0]  rc_q;
   logic [63:0] plaintext_q;

   logic [79:0] key_prev;
   logic [63:0] invp_out;
   logic [63:0] invs_out;
   logic [63:0] round_res;

   // Round datapath: inverse key step runs beside InvP -> InvS -> XOR.
   always_comb begin
      key_prev  = key_update_inv(key_q, rc_q);
      invp_out  = inv_player(data_q);
      round_res = invs_out ^ key_prev[79:16];
   end

   present_inv_sbox_layer u_inv_sbox (
      .data_i (invp_out),
      .data_o (invs_out)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: key expansion, whitening, then the inverse rounds.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = KEXP;
         KEXP:    if (rc_q == RC_LAST) state_d = WHITEN;
         WHITEN:  state_d = DEC;
         DEC:     if (rc_q == 5'd1) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
   end

   // Key register, cipher state, round counter and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q       <= '0;
         data_q      <= '0;
         rc_q        <= '0;
         plaintext_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  key_q  <= key;
                  data_q <= ciphertext;
                  rc_q   <= 5'd1;
               end
            end
            KEXP: begin
               key_q <= key_update_fwd(key_q, rc_q);
               // Counter parks at the last round so DEC starts from it.
               rc_q  <= (rc_q == RC_LAST) ? RC_LAST : rc_q + 5'd1;
            end
            WHITEN: begin
               data_q <= data_q ^ key_q[79:16];
            end
            DEC: begin
               key_q  <= key_prev;
               data_q <= round_res;
               rc_q   <= rc_q - 5'd1;
               if (rc_q == 5'd1) begin
                  plaintext_q <= round_res;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign plaintext = plaintext_q;

endmodule
